// File: rtl/uart_tx_arbiter_if.sv
// Byte-stream requester channel: a requester presents valid/data/last and
// the arbiter answers with ready; a byte moves when valid and ready are both high.
interface uart_tx_arbiter_if;
    logic       valid;
    logic [7:0] data;
    logic       last;
    logic       ready;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/uart_tx_arbiter.sv
// Two-requester arbiter feeding one UART transmitter. Multi-byte messages lock
// the owner; single bytes alternate fairly. Aborts if tx_busy never rises.
module uart_tx_arbiter #(
    parameter int unsigned BUSY_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    uart_tx_arbiter_if.slave  i_req0,
    uart_tx_arbiter_if.slave  i_req1,
    output logic              o_tx_start,
    output logic [7:0]        o_tx_data,
    input  logic              i_tx_busy,
    output logic [1:0]        o_owner,
    output logic              o_err_timeout
);

    typedef enum logic [1:0] {
        ARB       = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    // Abort is flagged on the cycle whose increment makes the counter reach BUSY_TIMEOUT-1.
    localparam logic [7:0] TIMEOUT_PRE = 8'(BUSY_TIMEOUT - 2);

    state_t     r_state;
    logic       r_tx_start;
    logic [7:0] r_tx_data;
    logic [1:0] r_owner;
    logic       r_err_timeout;
    logic [7:0] r_cnt;
    logic       r_last_served;

    state_t     w_state_nxt;
    logic       w_tx_start_nxt;
    logic [7:0] w_tx_data_nxt;
    logic [1:0] w_owner_nxt;
    logic       w_err_nxt;
    logic [7:0] w_cnt_nxt;
    logic       w_last_served_nxt;
    logic       w_grant0;
    logic       w_grant1;
    logic       w_last_byte;

    // Grant decision: ARB only, lock owner first, otherwise alternate on a tie.
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (!reset && (r_state == ARB)) begin
            case (r_owner)
                2'b01:   w_grant0 = i_req0.valid;
                2'b10:   w_grant1 = i_req1.valid;
                default: begin
                    if (i_req0.valid && i_req1.valid) begin
                        if (r_last_served) begin
                            w_grant0 = 1'b1;
                        end else begin
                            w_grant1 = 1'b1;
                        end
                    end else begin
                        w_grant0 = i_req0.valid;
                        w_grant1 = i_req1.valid;
                    end
                end
            endcase
        end else begin
            w_grant0 = 1'b0;
            w_grant1 = 1'b0;
        end
    end

    assign i_req0.ready = w_grant0;
    assign i_req1.ready = w_grant1;

    // Next-state and next-value logic for every registered output.
    always_comb begin
        w_state_nxt       = r_state;
        w_tx_start_nxt    = 1'b0;
        w_tx_data_nxt     = r_tx_data;
        w_owner_nxt       = r_owner;
        w_err_nxt         = 1'b0;
        w_cnt_nxt         = r_cnt;
        w_last_served_nxt = r_last_served;
        w_last_byte       = 1'b0;
        case (r_state)
            ARB: begin
                if (w_grant0 || w_grant1) begin
                    w_state_nxt       = ISSUE;
                    w_tx_start_nxt    = 1'b1;
                    w_tx_data_nxt     = w_grant1 ? i_req1.data : i_req0.data;
                    w_last_served_nxt = w_grant1;
                    w_last_byte       = w_grant1 ? i_req1.last : i_req0.last;
                    if (w_last_byte) begin
                        w_owner_nxt = 2'b00;
                    end else begin
                        w_owner_nxt = {w_grant1, w_grant0};
                    end
                end else begin
                    w_state_nxt = ARB;
                end
            end
            ISSUE: begin
                w_cnt_nxt   = 8'd0;
                w_state_nxt = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (i_tx_busy) begin
                    w_state_nxt = WAIT_DONE;
                end else if (r_cnt >= TIMEOUT_PRE) begin
                    w_cnt_nxt   = r_cnt + 8'd1;
                    w_err_nxt   = 1'b1;
                    w_owner_nxt = 2'b00;
                    w_state_nxt = ARB;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            WAIT_DONE: begin
                if (!i_tx_busy) begin
                    w_state_nxt = ARB;
                end else begin
                    w_state_nxt = WAIT_DONE;
                end
            end
            default: begin
                w_state_nxt = ARB;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ARB;
            r_tx_start    <= 1'b0;
            r_tx_data     <= 8'h00;
            r_owner       <= 2'b00;
            r_err_timeout <= 1'b0;
            r_cnt         <= 8'd0;
            r_last_served <= 1'b1;
        end else begin
            r_state       <= w_state_nxt;
            r_tx_start    <= w_tx_start_nxt;
            r_tx_data     <= w_tx_data_nxt;
            r_owner       <= w_owner_nxt;
            r_err_timeout <= w_err_nxt;
            r_cnt         <= w_cnt_nxt;
            r_last_served <= w_last_served_nxt;
        end
    end

    assign o_tx_start    = r_tx_start;
    assign o_tx_data     = r_tx_data;
    assign o_owner       = r_owner;
    assign o_err_timeout = r_err_timeout;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a small UART model that holds
// tx_busy high for three cycles after it samples tx_start.
module tb_uart_tx_arbiter;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       tx_busy;
    logic       tx_start;
    logic [7:0] tx_data;
    logic [1:0] owner;
    logic       err_timeout;

    uart_tx_arbiter_if req0_if ();
    uart_tx_arbiter_if req1_if ();

    uart_tx_arbiter #(.BUSY_TIMEOUT(TO)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_req0       (req0_if),
        .i_req1       (req1_if),
        .o_tx_start   (tx_start),
        .o_tx_data    (tx_data),
        .i_tx_busy    (tx_busy),
        .o_owner      (owner),
        .o_err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int   test_cnt   = 0;
    int   fail_cnt   = 0;
    int   busy_cnt   = 0;
    logic uart_en    = 1'b1;
    logic prev_start = 1'b0;
    logic rdy0;
    logic rdy1;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        test_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int idx, input logic v, input logic [7:0] d, input logic l);
        if (idx == 0) begin
            req0_if.valid = v; req0_if.data = d; req0_if.last = l;
        end else begin
            req1_if.valid = v; req1_if.data = d; req1_if.last = l;
        end
    endtask

    // One clock: sample readies mid-cycle, run invariants, advance the UART model.
    task automatic tick();
        logic start_now;
        @(negedge clk);
        rdy0      = req0_if.ready;
        rdy1      = req1_if.ready;
        start_now = tx_start;
        check_value("ready_excl", 32'(rdy0 & rdy1), 32'd0);
        check_value("start_b2b", 32'(prev_start & start_now), 32'd0);
        prev_start = start_now;
        @(posedge clk);
        #1;
        if (busy_cnt != 0) busy_cnt--;
        if (uart_en && start_now) busy_cnt = 3;
        tx_busy = (busy_cnt != 0);
    endtask

    // Wait (bounded) for the first ready, then check grant, latency and issued byte.
    task automatic expect_grant(input string tag, input int exp_port, input logic [7:0] exp_data,
                                input logic [1:0] exp_owner, input int exp_n);
        int n   = 0;
        int got = -1;
        while (n < 60 && got < 0) begin
            tick();
            n++;
            if (rdy0) got = 0;
            else if (rdy1) got = 1;
        end
        check_value({tag, "_port"}, 32'(got), 32'(exp_port));
        if (exp_n > 0) check_value({tag, "_lat"}, 32'(n), 32'(exp_n));
        check_value({tag, "_start"}, 32'(tx_start), 32'd1);
        check_value({tag, "_data"}, 32'(tx_data), 32'(exp_data));
        check_value({tag, "_owner"}, 32'(owner), 32'(exp_owner));
    endtask

    initial begin
        int k;
        reset   = 1'b1;
        tx_busy = 1'b0;
        set_req(0, 1'b1, 8'h41, 1'b1);
        set_req(1, 1'b1, 8'h55, 1'b1);
        @(posedge clk);
        #1;
        check_value("rst_rdy0", 32'(req0_if.ready), 32'd0);
        check_value("rst_rdy1", 32'(req1_if.ready), 32'd0);
        check_value("rst_start", 32'(tx_start), 32'd0);
        check_value("rst_data", 32'(tx_data), 32'h00);
        check_value("rst_owner", 32'(owner), 32'd0);
        check_value("rst_err", 32'(err_timeout), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        set_req(1, 1'b0, 8'h55, 1'b1);

        // Single byte from req0 never locks
        expect_grant("t1", 0, 8'h41, 2'b00, 1);
        set_req(0, 1'b0, 8'h41, 1'b1);
        tick();
        check_value("t1_start_drop", 32'(tx_start), 32'd0);
        repeat (6) tick();
        check_value("t1_data_hold", 32'(tx_data), 32'h41);
        check_value("t1_owner", 32'(owner), 32'd0);
        check_value("t1_err", 32'(err_timeout), 32'd0);

        reset = 1'b1; busy_cnt = 0; tx_busy = 1'b0; prev_start = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Fair alternation with both valid
        set_req(0, 1'b1, 8'hAA, 1'b1);
        set_req(1, 1'b1, 8'h55, 1'b1);
        expect_grant("t2a", 0, 8'hAA, 2'b00, 1);
        expect_grant("t2b", 1, 8'h55, 2'b00, 6);
        expect_grant("t2c", 0, 8'hAA, 2'b00, 6);
        expect_grant("t2d", 1, 8'h55, 2'b00, 6);
        set_req(0, 1'b0, 8'hAA, 1'b1);
        set_req(1, 1'b0, 8'h55, 1'b1);

        // Locked message from req0 holds off req1, even when req0 pauses
        set_req(0, 1'b1, 8'h10, 1'b0);
        set_req(1, 1'b1, 8'h99, 1'b1);
        expect_grant("t3a", 0, 8'h10, 2'b01, 6);
        set_req(0, 1'b0, 8'h10, 1'b0);
        k = 0;
        repeat (12) begin
            tick();
            if (rdy0 || rdy1) k++;
        end
        check_value("t3_hold_rdy", 32'(k), 32'd0);
        check_value("t3_hold_owner", 32'(owner), 32'd1);
        set_req(0, 1'b1, 8'h11, 1'b0);
        expect_grant("t3b", 0, 8'h11, 2'b01, 1);
        set_req(0, 1'b1, 8'h12, 1'b1);
        expect_grant("t3c", 0, 8'h12, 2'b00, 6);
        set_req(0, 1'b0, 8'h12, 1'b1);
        expect_grant("t3d", 1, 8'h99, 2'b00, 6);
        set_req(1, 1'b0, 8'h99, 1'b1);
        repeat (6) tick();

        // Transmitter never goes busy
        uart_en = 1'b0;
        set_req(1, 1'b1, 8'h33, 1'b1);
        expect_grant("t4", 1, 8'h33, 2'b00, 1);
        set_req(1, 1'b0, 8'h33, 1'b1);
        k = 0;
        while (k < 40 && !err_timeout) begin
            tick();
            k++;
        end
        check_value("t4_timeout_lat", 32'(k - 1), 32'(TO - 1));
        check_value("t4_owner", 32'(owner), 32'd0);
        tick();
        check_value("t4_err_pulse", 32'(err_timeout), 32'd0);
        uart_en = 1'b1;
        set_req(0, 1'b1, 8'h44, 1'b1);
        expect_grant("t4_rearb", 0, 8'h44, 2'b00, 1);
        set_req(0, 1'b0, 8'h44, 1'b1);
        repeat (6) tick();

        // Reset while a locked req1 message sits in WAIT_DONE
        set_req(1, 1'b1, 8'h70, 1'b0);
        expect_grant("t5", 1, 8'h70, 2'b10, 1);
        set_req(1, 1'b1, 8'h71, 1'b0);
        tick();
        tick();
        check_value("t5_owner_locked", 32'(owner), 32'd2);
        set_req(0, 1'b1, 8'h21, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check_value("t5_rst_rdy0", 32'(req0_if.ready), 32'd0);
        check_value("t5_rst_rdy1", 32'(req1_if.ready), 32'd0);
        check_value("t5_rst_start", 32'(tx_start), 32'd0);
        check_value("t5_rst_data", 32'(tx_data), 32'h00);
        check_value("t5_rst_owner", 32'(owner), 32'd0);
        check_value("t5_rst_err", 32'(err_timeout), 32'd0);
        busy_cnt = 0; tx_busy = 1'b0; prev_start = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        expect_grant("t5_after", 0, 8'h21, 2'b00, 1);

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter BUSY_TIMEOUT, default 16, max cycles in WAIT_BUSY for tx_busy to rise before abort (range 2..255).
REQ-002 clk  input  1  clock; all state changes on its rising edge.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 req0_valid  input  1  requester 0 presents a byte.
REQ-005 req0_data  input  8  requester 0 byte.
REQ-006 req0_last  input  1  byte is the final byte of requester 0's message.
REQ-007 req0_ready  output  1  arbiter accepts requester 0's byte this cycle.
REQ-008 req1_valid / req1_data[7:0] / req1_last / req1_ready: identical meaning for requester 1.
REQ-009 tx_start  output  1  one-cycle start pulse to the UART transmitter.
REQ-010 tx_data  output  8  byte to the UART transmitter.
REQ-011 tx_busy  input  1  UART transmitter busy status.
REQ-012 owner  output  2  one-hot current message lock owner; 00 = unlocked.
REQ-013 err_timeout  output  1  one-cycle pulse: tx_busy never rose after tx_start.

Function
REQ-014 FSM states ARB, ISSUE, WAIT_BUSY, WAIT_DONE; all outputs registered except req0_ready/req1_ready (combinational from state, lock, last_served, valids).
REQ-015 Transfer on a requester = valid & ready in the same cycle; ready only in ARB, at most one ready high per cycle.
REQ-016 ARB, unlocked: only req0 valid -> req0_ready=1; only req1 valid -> req1_ready=1; both valid -> grant the requester not equal to last_served; neither -> both ready 0.
REQ-017 ARB, locked: only owner's ready may assert (when owner valid); the other requester is held off regardless of its valid.
REQ-018 On transfer: tx_data <= granted data, last_served <= granted index, state <= ISSUE.
REQ-019 On transfer with last=0: owner <= granted one-hot; with last=1: owner <= 00.
REQ-020 ISSUE lasts exactly one cycle with tx_start=1; tx_start is 0 in every other state; timeout counter cleared; state <= WAIT_BUSY.
REQ-021 tx_data holds constant from ISSUE until the next transfer.
REQ-022 WAIT_BUSY: tx_busy=1 -> WAIT_DONE; else counter increments; counter reaching BUSY_TIMEOUT-1 with tx_busy=0 -> err_timeout=1 for one cycle, owner <= 00, state <= ARB.
REQ-023 WAIT_DONE: tx_busy=0 -> ARB; else remain.
REQ-024 Latency: transfer cycle N -> tx_start high in cycle N+1; next ready no earlier than the cycle after tx_busy falls.
REQ-025 Valid deasserted by a locked owner keeps the lock; arbiter waits in ARB indefinitely.
REQ-026 Single-byte message (last=1 on first byte) never sets owner.
REQ-027 Data on a requester not granted is ignored; no buffering beyond tx_data.

Reset
REQ-028 Reset (any cycle, including mid-transfer): state ARB, tx_start 0, tx_data 0x00, owner 00, err_timeout 0, counter 0, last_served=1 (requester 0 wins first tie).
REQ-029 Byte in flight at reset is dropped; no tx_start issued for it after reset release.
REQ-030 Ready outputs 0 while reset asserted.

Verification
REQ-031 Reset then req0 valid 0x41 last=1, model UART busy 3 cycles after start -> req0_ready 1 cycle, tx_start next cycle, tx_data=0x41, owner stays 00.
REQ-032 Both valid continuously, last=1 each, req0=0xAA req1=0x55 -> tx_data sequence 0xAA,0x55,0xAA,0x55 (strict alternation).
REQ-033 req0 sends 0x10 last=0, 0x11 last=0, 0x12 last=1 while req1 valid 0x99 -> owner=01 across message, req1_ready 0 until after 0x12, then 0x99 sent.
REQ-034 tx_busy tied 0, req1 sends 0x33 -> tx_start pulse, err_timeout pulse exactly BUSY_TIMEOUT-1 cycles after WAIT_BUSY entry, back to ARB, owner 00.
REQ-035 Assert reset during WAIT_DONE of a locked message -> all outputs to reset values immediately, owner 00; after release, both valid -> req0 granted first.
REQ-036 Check every cycle: tx_start never high on two consecutive cycles; req0_ready & req1_ready never both 1.
